// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_boot_checker
// Purpose  : Avalon-MM master that reads the system-ID slave (word 0 = ID,
//            word 1 = build timestamp). It compares both words with the
//            expected values and drives sticky status flags that gate boot.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           in   1  system clock
//   reset_n         in   1  asynchronous active-low reset
//   start           in   1  one-cycle check request, ignored while busy
//   avm_address     out  1  word address (0 = ID, 1 = timestamp)
//   avm_read        out  1  read strobe, held while avm_waitrequest=1
//   avm_waitrequest in   1  slave stall
//   avm_readdata    in  32  slave read data
//   busy            out  1  check in progress
//   done            out  1  one-cycle pulse on completion or abort
//   id_ok           out  1  last captured ID matched EXPECTED_ID
//   ts_ok           out  1  last captured timestamp matched EXPECTED_TS
//   timeout         out  1  last check aborted on a waitrequest timeout
//   read_id         out 32  last captured ID word
//   read_ts         out 32  last captured timestamp word
// Optional build macro
//   SYSID_PERIODIC_RECHECK_EN : adds RECHECK_CYCLES and an idle counter.
//   The counter relaunches the check after RECHECK_CYCLES idle cycles.
// ============================================================================
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h6452_524A,
  parameter int          READ_LATENCY   = 0,    // 0..7
  parameter int          TIMEOUT_CYCLES = 255,  // 1..255
  parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_PERIODIC_RECHECK_EN
  ,
  parameter int          RECHECK_CYCLES = 1_000_000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_ID = 3'd1,
    S_LAT_ID = 3'd2,
    S_REQ_TS = 3'd3,
    S_LAT_TS = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam bit       LAT_ZERO = (READ_LATENCY == 0);
  // The abort fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  // This value is unused when LAT_ZERO is set. In that case the LAT_* states are never entered.
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t      state_q;
  logic        launch_q;
  logic [7:0]  tmo_q;
  logic [2:0]  lat_q;
  logic        read_q;
  logic        addr_q;
  logic        busy_q;
  logic        done_q;
  logic        id_ok_q;
  logic        ts_ok_q;
  logic        timeout_q;
  logic [31:0] read_id_q;
  logic [31:0] read_ts_q;

  logic launch_d;
  logic lat_last_d;
  assign launch_d   = start | launch_q;
  assign lat_last_d = (lat_q == LAT_LAST);

`ifdef SYSID_PERIODIC_RECHECK_EN
  localparam logic [23:0] RECHK_LAST = 24'(RECHECK_CYCLES - 1);
  logic [23:0] idle_cnt_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      launch_q  <= AUTO_START;
      tmo_q     <= '0;
      lat_q     <= '0;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      read_id_q <= '0;
      read_ts_q <= '0;
`ifdef SYSID_PERIODIC_RECHECK_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SYSID_PERIODIC_RECHECK_EN
      idle_cnt_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (launch_d) begin
            state_q   <= S_REQ_ID;
            launch_q  <= 1'b0;
            read_q    <= 1'b1;
            addr_q    <= 1'b0;
            busy_q    <= 1'b1;
            tmo_q     <= '0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
          end
`ifdef SYSID_PERIODIC_RECHECK_EN
          else if (idle_cnt_q == RECHK_LAST) begin
            launch_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 24'd1;
          end
`endif
        end

        S_REQ_ID: begin
          if (!avm_waitrequest) begin
            tmo_q <= '0;
            if (LAT_ZERO) begin
              read_id_q <= avm_readdata;
              addr_q    <= 1'b1;
              state_q   <= S_REQ_TS;
            end else begin
              read_q  <= 1'b0;
              lat_q   <= '0;
              state_q <= S_LAT_ID;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Abort. id_ok and ts_ok were cleared at launch and stay 0.
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        S_LAT_ID: begin
          if (lat_last_d) begin
            read_id_q <= avm_readdata;
            read_q    <= 1'b1;
            addr_q    <= 1'b1;
            state_q   <= S_REQ_TS;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end

        S_REQ_TS: begin
          if (!avm_waitrequest) begin
            tmo_q <= '0;
            if (LAT_ZERO) begin
              // The timestamp is compared as it is captured.
              // Because of this, the flags are valid in the done cycle.
              read_ts_q <= avm_readdata;
              read_q    <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              id_ok_q   <= (read_id_q == EXPECTED_ID);
              ts_ok_q   <= (avm_readdata == EXPECTED_TS);
              state_q   <= S_FINISH;
            end else begin
              read_q  <= 1'b0;
              lat_q   <= '0;
              state_q <= S_LAT_TS;
            end
          end else if (tmo_q == TMO_LAST) begin
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        S_LAT_TS: begin
          if (lat_last_d) begin
            read_ts_q <= avm_readdata;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            id_ok_q   <= (read_id_q == EXPECTED_ID);
            ts_ok_q   <= (avm_readdata == EXPECTED_TS);
            state_q   <= S_FINISH;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end

        // This is the done cycle. A start that arrives here is deliberately not looked at.
        S_FINISH: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_boot_checker
// Purpose  : Self-checking bench for sysid_boot_checker. It builds two DUTs:
//            (A) READ_LATENCY=0 and (B) READ_LATENCY=2, both with
//            TIMEOUT_CYCLES=4 and AUTO_START=1. Each DUT has its own
//            behavioural sysid slave with programmable stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_boot_checker;

  localparam int          T      = 4;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h6452_524A;
  localparam logic [31:0] BAD    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [2];
  logic        start_s [2];
  logic [31:0] mem       [2][2];
  int          stall_cfg [2][2];
  int          scnt      [2] = '{0, 0};

  logic        rd_a, ad_a, wt_a, busy_a, done_a, idok_a, tsok_a, to_a;
  logic [31:0] rdata_a, rid_a, rts_a;
  logic        rd_b, ad_b, wt_b, busy_b, done_b, idok_b, tsok_b, to_b;
  logic [31:0] rdata_b, rid_b, rts_b;

  sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)) dut_a (
    .clock(clk), .reset_n(rstn[0]), .start(start_s[0]),
    .avm_address(ad_a), .avm_read(rd_a), .avm_waitrequest(wt_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout(to_a),
    .read_id(rid_a), .read_ts(rts_a));

  sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)) dut_b (
    .clock(clk), .reset_n(rstn[1]), .start(start_s[1]),
    .avm_address(ad_b), .avm_read(rd_b), .avm_waitrequest(wt_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout(to_b),
    .read_id(rid_b), .read_ts(rts_b));

  // Slave model. Each read stalls for stall_cfg[addr] cycles, then it is accepted.
  // Data is driven only in the cycle it is valid. Outside that cycle the slave drives a poison value.
  assign wt_a    = rd_a && (scnt[0] < stall_cfg[0][ad_a]);
  assign rdata_a = (rd_a && !wt_a) ? mem[0][ad_a] : BAD;
  assign wt_b    = rd_b && (scnt[1] < stall_cfg[1][ad_b]);

  logic acc1_b = 1'b0, acc2_b = 1'b0, a1_b = 1'b0, a2_b = 1'b0;
  always @(posedge clk) begin
    scnt[0] <= (rd_a && wt_a) ? scnt[0] + 1 : 0;
    scnt[1] <= (rd_b && wt_b) ? scnt[1] + 1 : 0;
    acc1_b  <= rd_b && !wt_b;
    a1_b    <= ad_b;
    acc2_b  <= acc1_b;
    a2_b    <= a1_b;
  end
  assign rdata_b = acc2_b ? mem[1][a2_b] : BAD;

  function automatic logic [68:0] status(input int s);
    if (s == 0) return {busy_a, done_a, idok_a, tsok_a, to_a, rid_a, rts_a};
    return {busy_b, done_b, idok_b, tsok_b, to_b, rid_b, rts_b};
  endfunction

  function automatic logic [2:0] bus(input int s);
    if (s == 0) return {rd_a, ad_a, wt_a};
    return {rd_b, ad_b, wt_b};
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the last values that were captured successfully, for each DUT.
  logic [31:0] m_rid [2];
  logic [31:0] m_rts [2];

  // Outcome of one check, computed from the stall counts and the data words.
  task automatic model(input int s, input logic [31:0] w0, input logic [31:0] w1,
                       input int st0, input int st1,
                       output int off, output logic idok, output logic tsok, output logic to);
    int lat;
    lat = (s == 1) ? 2 : 0;
    if (st0 >= T) begin
      off = 1 + T; idok = 1'b0; tsok = 1'b0; to = 1'b1;
    end else if (st1 >= T) begin
      off = 1 + (st0 + 1 + lat) + T; idok = 1'b0; tsok = 1'b0; to = 1'b1;
    end else begin
      off = 1 + (st0 + 1 + lat) + (st1 + 1 + lat);
      idok = (w0 == EXP_ID); tsok = (w1 == EXP_TS); to = 1'b0;
    end
  endtask

  // Launches a check at the current negedge (cycle N). The launch is a start pulse or a reset release.
  // busy/done is checked every cycle, and so is the hold/abort behaviour during stalls.
  task automatic run_check(input string name, input int s, input bit use_start, input bit spam,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input int st0, input int st1, input int off,
                           input logic e_idok, input logic e_tsok, input logic e_to);
    logic [2:0]  pb, cb;
    logic [68:0] st;
    int          pscnt;
    mem[s][0] = w0; mem[s][1] = w1;
    stall_cfg[s][0] = st0; stall_cfg[s][1] = st1;
    if (use_start) start_s[s] = 1'b1;
    else           rstn[s]    = 1'b1;
    pb = bus(s); pscnt = scnt[s];
    for (int k = 1; k <= off + 4; k++) begin
      @(negedge clk);
      start_s[s] = spam && (k == 2 || k == off);
      cb = bus(s);
      st = status(s);
      chk($sformatf("%s busy/done k=%0d", name, k), st[68:67], {(k < off), (k == off)});
      if (pb[2] && pb[0]) begin
        if (pscnt + 1 < T) chk($sformatf("%s stall hold k=%0d", name, k), cb[2:1], {1'b1, pb[1]});
        else               chk($sformatf("%s stall abort k=%0d", name, k), cb[2], 1'b0);
      end
      pb = cb; pscnt = scnt[s];
    end
    if (st0 < T) m_rid[s] = w0;
    if (st0 < T && st1 < T) m_rts[s] = w1;
    st = status(s);
    chk({name, " flags"},   st[66:64], {e_idok, e_tsok, e_to});
    chk({name, " read_id"}, st[63:32], m_rid[s]);
    chk({name, " read_ts"}, st[31:0],  m_rts[s]);
  endtask

  typedef struct {
    int          s;
    bit          use_start;
    bit          spam;
    logic [31:0] w0;
    logic [31:0] w1;
    int          st0;
    int          st1;
    int          off;
    logic        idok;
    logic        tsok;
    logic        to;
  } vec_t;

  vec_t        vecs [11];
  logic [68:0] st;
  logic [2:0]  cb;

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mem[s][0] = EXP_ID; mem[s][1] = EXP_TS;
      stall_cfg[s][0] = 0; stall_cfg[s][1] = 0;
      m_rid[s] = '0; m_rts[s] = '0;
    end
    //          s  st sp  w0             w1             st0 st1 off idok tsok to
    vecs[0]  = '{0, 0, 0, EXP_ID,        EXP_TS,        0,  0,  3,  1,   1,   0};
    vecs[1]  = '{1, 0, 0, EXP_ID,        EXP_TS,        0,  0,  7,  1,   1,   0};
    vecs[2]  = '{0, 1, 0, EXP_ID,        32'h6452524B,  0,  0,  3,  1,   0,   0};
    vecs[3]  = '{1, 1, 0, EXP_ID,        EXP_TS,        3,  0,  10, 1,   1,   0};
    vecs[4]  = '{0, 1, 0, EXP_ID,        EXP_TS,        99, 0,  5,  0,   0,   1};
    vecs[5]  = '{1, 1, 0, EXP_ID,        EXP_TS,        0,  99, 8,  0,   0,   1};
    vecs[6]  = '{0, 1, 1, EXP_ID,        EXP_TS,        0,  0,  3,  1,   1,   0};
    vecs[7]  = '{1, 1, 1, 32'h00000001,  EXP_TS,        0,  0,  7,  0,   1,   0};
    vecs[8]  = '{0, 1, 0, EXP_ID,        EXP_TS,        3,  0,  6,  1,   1,   0};
    vecs[9]  = '{0, 1, 0, 32'h12345678,  EXP_TS,        0,  4,  6,  0,   0,   1};
    vecs[10] = '{1, 1, 0, EXP_ID,        32'h00000000,  1,  2,  10, 1,   0,   0};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      st = status(s); cb = bus(s);
      chk($sformatf("reset status dut%0d", s), st, '0);
      chk($sformatf("reset bus dut%0d", s), cb[2:1], 2'b00);
    end

    for (int i = 0; i < 11; i++)
      run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].use_start, vecs[i].spam,
                vecs[i].w0, vecs[i].w1, vecs[i].st0, vecs[i].st1,
                vecs[i].off, vecs[i].idok, vecs[i].tsok, vecs[i].to);

    for (int i = 0; i < 14; i++) begin
      int          s, st0, st1, off;
      logic [31:0] w0, w1;
      logic        e_idok, e_tsok, e_to;
      bit          spam;
      s    = int'($urandom_range(0, 1));
      w0   = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
      w1   = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
      st0  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      st1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      spam = ($urandom_range(0, 1) == 1);
      model(s, w0, w1, st0, st1, off, e_idok, e_tsok, e_to);
      run_check($sformatf("rnd%0d", i), s, 1'b1, spam, w0, w1, st0, st1, off, e_idok, e_tsok, e_to);
    end

    // Start a check on DUT B and assert reset while it is in LAT_TS (cycle 5 of the check).
    mem[1][0] = EXP_ID; mem[1][1] = EXP_TS;
    stall_cfg[1][0] = 0; stall_cfg[1][1] = 0;
    start_s[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_s[1] = 1'b0;
    end
    st = status(1);
    chk("midrst busy before", st[68], 1'b1);
    rstn[1] = 1'b0;
    #1;
    st = status(1); cb = bus(1);
    chk("midrst async status", st, '0);
    chk("midrst async bus", cb[2:1], 2'b00);
    m_rid[1] = '0; m_rts[1] = '0;
    repeat (2) @(negedge clk);
    run_check("midrst rerun", 1, 1'b0, 1'b0, EXP_ID, EXP_TS, 0, 0, 7, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave (control_slave: 1-bit address, 32-bit readdata).
- After reset, or on a start pulse, it reads word 0 (system ID) and word 1 (build timestamp).
- It compares both words against expected values and drives sticky status flags that gate boot and report configuration mismatches.

Parameters:
- EXPECTED_ID, 32'h00000000, value required at address 0
- EXPECTED_TS, 32'h6452524A, value required at address 1 (1683116618 decimal)
- READ_LATENCY, 0, cycles from accepted read to valid readdata (0 = combinational slave, max 7)
- TIMEOUT_CYCLES, 255, max cycles avm_read may be held by waitrequest before abort (8-bit counter, nonzero)
- AUTO_START, 1, 1 = run one check automatically after reset release

Ports:
- clock, input, 1, system clock
- reset_n, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle pulse requesting a check; ignored while busy
- avm_address, output, 1, word address to sysid slave
- avm_read, output, 1, read strobe
- avm_waitrequest, input, 1, slave stall; tie 0 for a zero-wait slave
- avm_readdata, input, 32, slave read data
- busy, output, 1, check in progress
- done, output, 1, one-cycle pulse when a check completes or aborts
- id_ok, output, 1, last captured ID equals EXPECTED_ID
- ts_ok, output, 1, last captured timestamp equals EXPECTED_TS
- timeout, output, 1, last check aborted on waitrequest timeout
- read_id, output, 32, last captured ID word
- read_ts, output, 32, last captured timestamp word

Behaviour:
- Reset values: all outputs 0. State IDLE. Timeout and latency counters 0. Launch flag set iff AUTO_START=1.
- States: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FINISH.
- IDLE -> REQ_ID on start=1 or pending launch flag; launch flag cleared on entry. At entry, clear id_ok, ts_ok and timeout; read_id and read_ts keep their old values.
- REQ_ID: avm_read=1, avm_address=0, busy=1.
  - Read is accepted on the first cycle with avm_waitrequest=0.
  - If READ_LATENCY=0, capture avm_readdata into read_id in the accept cycle and go to REQ_TS.
  - Otherwise go to LAT_ID, with avm_read low.
- LAT_ID: count READ_LATENCY cycles, capture on the last one, then go to REQ_TS.
- REQ_TS / LAT_TS: same as REQ_ID / LAT_ID with address 1, capturing into read_ts, then go to FINISH.
- Address and read are registered outputs and held stable while waitrequest=1.
- Timeout:
  - Counter increments each REQ_* cycle with waitrequest=1 and resets on accept.
  - When it reaches TIMEOUT_CYCLES: deassert read, set timeout=1, go to FINISH with id_ok=ts_ok=0.
- FINISH:
  - On the normal path, set id_ok=(read_id==EXPECTED_ID) and ts_ok=(read_ts==EXPECTED_TS).
  - Pulse done for one cycle, deassert busy, return to IDLE.
- Latency, zero-wait slave with READ_LATENCY=0: start seen in cycle N, read_id captured N+1, read_ts captured N+2, done in N+3.
- start asserted while busy is dropped, not queued. start in the same cycle as done is dropped.
- Asynchronous reset mid-check: immediately returns to reset values. AUTO_START re-arms the launch, so a fresh check runs after release.
- Comparison is full 32-bit equality with no masking.

Optional Feature:
- Macro: SYSID_PERIODIC_RECHECK_EN.
- When defined:
  - Add parameter RECHECK_CYCLES (default 1_000_000) and a 24-bit idle counter, which runs only in IDLE.
  - When the counter reaches RECHECK_CYCLES, the launch flag is set and the counter clears.
  - Any start or check resets the counter.
  - Sticky flags update on each recheck.
- When undefined: no counter logic; checks occur only at reset (AUTO_START) or on start.

Test Plan:
- Zero-wait slave returning 0 at address 0 and 32'h6452524A at address 1, AUTO_START=1, reset released -> read at addr 0 then addr 1 in consecutive cycles; done pulses at cycle 3; id_ok=1, ts_ok=1, timeout=0, busy low afterward.
- Slave returns 32'h6452524B at address 1, start pulse -> read_ts=32'h6452524B, ts_ok=0, id_ok=1, one done pulse.
- waitrequest held 3 cycles on the ID read, READ_LATENCY=2 -> address and read stable during the stall; capture 2 cycles after accept; correct flags; done at start+1+3+3+3.
- waitrequest stuck high, TIMEOUT_CYCLES=4 -> read dropped after 4 stall cycles; timeout=1, id_ok=ts_ok=0, done pulses once.
- start pulsed during busy, and again in the done cycle -> exactly one check executes; no second done.
- reset_n asserted during LAT_TS -> outputs 0 asynchronously; after release with AUTO_START=1 a full check reruns and passes.
